// File: rtl/vga_text_buf.sv
// Text-mode frame buffer: consumes a UART byte stream into character cells
// and renders them through an external 8x16 font ROM on the VGA pixel path.
module vga_text_buf #(
  parameter int          COLS     = 80,
  parameter int          ROWS     = 30,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_row,
  output logic [23:0] vga_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam int          N       = COLS * ROWS;
  localparam logic [11:0] LAST    = 12'(N - 1);
  localparam logic [11:0] SHIFT_N = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] COLS_W  = 12'(COLS);
  localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_SCROLL
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        rdy_q;

  logic [7:0]  mem [N];

  logic        we;
  logic [11:0] waddr;
  logic [7:0]  wdata;
  logic        nl;
  logic        is_print;
  logic [11:0] cur_idx;
  logic [11:0] shift_idx;

  assign cur_idx   = 12'(row_q * COLS + col_q);
  assign shift_idx = cnt_q + COLS_W;
  assign is_print  = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    we      = 1'b0;
    waddr   = cnt_q;
    wdata   = 8'h20;
    nl      = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_SCROLL: begin
        we    = 1'b1;
        cnt_d = cnt_q + 12'd1;
        if (cnt_q < SHIFT_N)
          wdata = mem[shift_idx];
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (rx_valid) begin
          waddr = cur_idx;
          unique case (1'b1)
            is_print: begin
              we    = 1'b1;
              wdata = rx_data;
              if (col_q == COL_MAX) begin
                col_d = '0;
                nl    = 1'b1;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
            rx_data == 8'h0A: begin
              col_d = '0;
              nl    = 1'b1;
            end
            rx_data == 8'h0D: col_d = '0;
            rx_data == 8'h08: begin
              if (col_q != '0) begin
                col_d = col_q - 7'd1;
                we    = 1'b1;
                waddr = cur_idx - 12'd1;
              end
            end
            default: ;
          endcase
          // Newline on the last row pins the cursor and shifts the page up
          if (nl) begin
            if (row_q == ROW_MAX) begin
              state_d = S_SCROLL;
              cnt_d   = '0;
            end else begin
              row_d = row_q + 5'd1;
            end
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rdy_q   <= (state_d == S_IDLE);
    end
  end

  // Cell storage is deliberately not reset; CLEAR sweeps it afterwards
  always_ff @(posedge pclk) begin
    if (we && !reset)
      mem[waddr] <= wdata;
  end

  assign rx_ready   = rdy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  logic [11:0] disp_idx;
  logic        disp_ok;
  logic [7:0]  disp_char;
  logic        pixel;

  assign disp_idx  = 12'(v_addr[8:4] * COLS + h_addr[9:3]);
  assign disp_ok   = !v_addr[9] && (disp_idx < 12'(N));
  assign disp_char = disp_ok ? mem[disp_idx] : 8'h20;
  assign font_addr = {disp_char, v_addr[3:0]};
  assign pixel     = font_row[3'd7 - h_addr[2:0]];
  assign vga_data  = !valid ? 24'h000000
                   : pixel  ? FG_COLOR
                   :          BG_COLOR;

endmodule

// File: tb/tb_vga_text_buf.sv
// Directed + randomized bench for vga_text_buf against a page-level
// model of the character grid and cursor.
module tb_vga_text_buf;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int N    = COLS * ROWS;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic [9:0]  h_addr = '0;
  logic [9:0]  v_addr = '0;
  logic        valid = 1'b0;
  logic [11:0] font_addr;
  logic [7:0]  font_row = 8'h00;
  logic [23:0] vga_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int vectors = 0;
  int errs    = 0;

  logic [7:0] mbuf [N];
  int mcol = 0;
  int mrow = 0;

  always #5 pclk = ~pclk;

  vga_text_buf dut (
    .pclk       (pclk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .valid      (valid),
    .font_addr  (font_addr),
    .font_row   (font_row),
    .vga_data   (vga_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic model_put(input logic [7:0] b, output bit scr);
    bit nl;
    nl  = 1'b0;
    scr = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      mbuf[mrow*COLS + mcol] = b;
      if (mcol == COLS-1) begin mcol = 0; nl = 1'b1; end
      else mcol++;
    end else if (b == 8'h0A) begin
      mcol = 0; nl = 1'b1;
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08 && mcol > 0) begin
      mcol--;
      mbuf[mrow*COLS + mcol] = 8'h20;
    end
    if (nl) begin
      if (mrow == ROWS-1) begin
        scr = 1'b1;
        for (int r = 0; r < ROWS-1; r++)
          for (int c = 0; c < COLS; c++)
            mbuf[r*COLS + c] = mbuf[(r+1)*COLS + c];
        for (int c = 0; c < COLS; c++)
          mbuf[(ROWS-1)*COLS + c] = 8'h20;
      end else begin
        mrow++;
      end
    end
  endtask

  task automatic measure(input string tag);
    int n;
    n = 0;
    while (!rx_ready && n < 6000) begin
      @(posedge pclk); #1; n++;
    end
    chk(tag, n, N);
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_col"}, 32'(cursor_col), mcol);
    chk({tag, "_row"}, 32'(cursor_row), mrow);
  endtask

  task automatic send(input logic [7:0] b, input bit await_scroll);
    int w;
    bit scr;
    w = 0;
    while (!rx_ready && w < 6000) begin
      @(posedge pclk); #1; w++;
    end
    if (!rx_ready) chk("ready_timeout", 32'(rx_ready), 1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge pclk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    model_put(b, scr);
    if (scr && await_scroll) measure("scroll_len");
    chk_cursor("cursor");
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] ch);
    h_addr = 10'(c*8 + $urandom_range(0, 7));
    v_addr = 10'(r*16 + $urandom_range(0, 15));
    #1;
    ch = font_addr[11:4];
    chk("font_low", 32'(font_addr[3:0]), 32'(v_addr[3:0]));
  endtask

  task automatic check_cell(input string tag, input int r, input int c,
                            input logic [7:0] exp);
    logic [7:0] ch;
    read_cell(r, c, ch);
    chk(tag, 32'(ch), 32'(exp));
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        check_cell(tag, r, c, mbuf[r*COLS + c]);
  endtask

  function automatic logic [7:0] rnd_byte();
    int k;
    k = $urandom_range(0, 39);
    if (k == 0) return 8'h0A;
    if (k == 1) return 8'h0D;
    if (k <= 4) return 8'h08;
    if (k == 5) return 8'($urandom_range(0, 31));
    if (k == 6) return 8'($urandom_range(127, 255));
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    logic [7:0] last;
    logic [7:0] ch;
    int hx, vy;
    logic [23:0] ev;
    bit px;

    // Reset with a byte offered throughout; it must be ignored
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    #2;
    chk("rst_ready", 32'(rx_ready), 0);
    chk("rst_col", 32'(cursor_col), 0);
    chk("rst_row", 32'(cursor_row), 0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    measure("clear_len");
    rx_valid = 1'b0;
    model_clear();
    chk_cursor("post_clear");
    h_addr = 10'd0;
    v_addr = 10'd0;
    #1;
    chk("clear_font00", 32'(font_addr), 32'h200);
    check_all("clear_cells");

    // Single printable byte and display path
    send(8'h41, 1'b1);
    check_cell("cell_A", 0, 0, 8'h41);
    h_addr = 10'd0; v_addr = 10'd0; font_row = 8'h80; valid = 1'b1;
    #1;
    chk("pix_fg", 32'(vga_data), 32'hFFFFFF);
    valid = 1'b0;
    #1;
    chk("pix_blank", 32'(vga_data), 32'h0);
    valid = 1'b1; font_row = 8'h7F;
    #1;
    chk("pix_bg", 32'(vga_data), 32'h0);

    // Backspace and carriage return
    send(8'h0D, 1'b1);
    send(8'h08, 1'b1);
    check_cell("bs0_cell", 0, 0, 8'h41);
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    send(8'h08, 1'b1);
    chk("bs_col", 32'(cursor_col), 1);
    check_cell("bs_cell", 0, 1, 8'h20);
    send(8'h42, 1'b1);
    send(8'h0D, 1'b1);
    chk("cr_col", 32'(cursor_col), 0);
    chk("cr_row", 32'(cursor_row), 0);

    // Line wrap
    last = 8'h20;
    for (int i = 0; i < COLS; i++) begin
      last = 8'($urandom_range(32, 126));
      send(last, 1'b1);
    end
    chk("wrap_col", 32'(cursor_col), 0);
    chk("wrap_row", 32'(cursor_row), 1);
    check_cell("wrap_last", 0, COLS-1, last);
    check_all("wrap_cells");

    // Reset 100 cycles into a scroll
    while (mrow < ROWS-1) send(8'h0A, 1'b1);
    send(8'h0A, 1'b0);
    chk("scroll_busy", 32'(rx_ready), 0);
    repeat (100) @(posedge pclk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_col", 32'(cursor_col), 0);
    chk("midrst_row", 32'(cursor_row), 0);
    chk("midrst_ready", 32'(rx_ready), 0);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    measure("reclear_len");
    model_clear();
    check_all("reclear_cells");

    // Directed scroll
    send(8'h58, 1'b1);
    send(8'h0A, 1'b1);
    send(8'h59, 1'b1);
    while (mrow < ROWS-1) send(8'h0A, 1'b1);
    send(8'h0A, 1'b1);
    check_cell("scroll_00", 0, 0, 8'h59);
    for (int c = 0; c < COLS; c++)
      check_cell("scroll_lastrow", ROWS-1, c, 8'h20);
    chk("scroll_col", 32'(cursor_col), 0);
    chk("scroll_row", 32'(cursor_row), ROWS-1);
    check_all("scroll_cells");

    // Randomized byte stream
    for (int i = 0; i < 200; i++) send(rnd_byte(), 1'b1);
    check_all("rand_cells");

    // Randomized display lookups
    for (int i = 0; i < 40; i++) begin
      hx = $urandom_range(0, 639);
      vy = $urandom_range(0, 479);
      h_addr   = 10'(hx);
      v_addr   = 10'(vy);
      font_row = 8'($urandom);
      valid    = 1'($urandom);
      #1;
      ch = mbuf[(vy/16)*COLS + hx/8];
      chk("rand_font", 32'(font_addr), 32'({ch, 4'(vy % 16)}));
      px = font_row[7 - (hx % 8)];
      ev = !valid ? 24'h0 : (px ? 24'hFFFFFF : 24'h000000);
      chk("rand_pix", 32'(vga_data), 32'(ev));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
